// File: rtl/ps2_host_fifo.sv
// PS/2 host controller with receive FIFO, start/parity/stop checking, per-bit watchdog and valid/ready TX.
// Optional input glitch filter: define PS2_HOST_GLITCH_FILTER_EN.
module ps2_host_fifo #(
  parameter int unsigned INHIBIT_CYCLES = 8191,
  parameter int unsigned RX_DEPTH       = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ps2_clk_d,
  input  logic                      ps2_data_d,
  output logic                      ps2_clk_q,
  output logic                      ps2_data_q,
  input  logic [7:0]                tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic                      tx_done,
  output logic                      tx_err,
  output logic [7:0]                rx_data,
  output logic                      rx_valid,
  input  logic                      rx_rd,
  output logic [$clog2(RX_DEPTH):0] rx_count,
  output logic                      rx_err,
  output logic                      rx_overflow
);

  localparam int unsigned PTR_W   = $clog2(RX_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned TMR_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] INHIBIT_LOAD = TMR_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] WD_LOAD      = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RX, TX_INHIBIT, TX_REQ, TX_ACK} state_e;

  // Pad synchronisers and falling-edge detector.
  logic [1:0] clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic       clk_prev_q, clk_prev_d;
  logic       clk_s, data_s, fe;

  assign clk_sync_d  = {clk_sync_q[0], ps2_clk_d};
  assign data_sync_d = {data_sync_q[0], ps2_data_d};

`ifdef PS2_HOST_GLITCH_FILTER_EN
  // A filtered line follows its synchronised input only after 8 consecutive differing samples.
  logic       clk_filt_q, clk_filt_d, data_filt_q, data_filt_d;
  logic [2:0] clk_run_q, clk_run_d, data_run_q, data_run_d;

  always_comb begin
    clk_filt_d  = clk_filt_q;
    clk_run_d   = '0;
    data_filt_d = data_filt_q;
    data_run_d  = '0;
    if (clk_sync_q[1] != clk_filt_q) begin
      if (clk_run_q == 3'd7) clk_filt_d = clk_sync_q[1];
      else                   clk_run_d  = clk_run_q + 3'd1;
    end
    if (data_sync_q[1] != data_filt_q) begin
      if (data_run_q == 3'd7) data_filt_d = data_sync_q[1];
      else                    data_run_d  = data_run_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_filt_q  <= 1'b1;
      data_filt_q <= 1'b1;
      clk_run_q   <= '0;
      data_run_q  <= '0;
    end else begin
      clk_filt_q  <= clk_filt_d;
      data_filt_q <= data_filt_d;
      clk_run_q   <= clk_run_d;
      data_run_q  <= data_run_d;
    end
  end

  assign clk_s  = clk_filt_q;
  assign data_s = data_filt_q;
`else
  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
`endif

  assign clk_prev_d = clk_s;
  assign fe         = clk_prev_q & ~clk_s;

  // Frame FSM state.
  state_e           state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [10:0]      shift_q, shift_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             clk_drv_q, clk_drv_d, data_drv_q, data_drv_d;
  logic             tx_ready_q, tx_ready_d;
  logic             tx_done_q, tx_done_d, tx_err_q, tx_err_d;
  logic             rx_err_q, rx_err_d, rx_ovf_q, rx_ovf_d;
  logic             frame_ok, tmr_zero, tx_fire;
  logic [9:0]       tx_frame;

  assign tx_fire  = tx_valid & tx_ready_q;
  assign tmr_zero = (tmr_q == '0);
  // Host frame after the start bit: d0..d7, odd parity, stop (stop = released line).
  assign tx_frame = {1'b1, ~^tx_byte_q, tx_byte_q};

  always_comb begin
    // NOTE: every combinational output gets a default before the case, so no path can infer a latch.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_byte_d  = tx_byte_q;
    tmr_d      = tmr_q;
    clk_drv_d  = 1'b0;
    data_drv_d = 1'b0;
    tx_done_d  = 1'b0;
    tx_err_d   = 1'b0;
    rx_err_d   = 1'b0;
    frame_ok   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A TX handshake wins over a simultaneous start-bit edge.
        if (tx_fire) begin
          state_d   = TX_INHIBIT;
          tx_byte_d = tx_data;
          tmr_d     = INHIBIT_LOAD;
          clk_drv_d = 1'b1;
        end else if (fe && !data_s) begin
          state_d   = RX;
          bit_cnt_d = 4'd1;
          shift_d   = {data_s, shift_q[10:1]};
          tmr_d     = WD_LOAD;
        end
      end
      RX: begin
        if (fe) begin
          shift_d   = {data_s, shift_q[10:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          tmr_d     = WD_LOAD;
          if (bit_cnt_q == 4'd10) begin
            state_d = IDLE;
            if (!shift_d[0] && (^shift_d[9:1]) && shift_d[10]) frame_ok = 1'b1;
            else                                               rx_err_d = 1'b1;
          end
        end else if (tmr_zero) begin
          state_d  = IDLE;
          rx_err_d = 1'b1;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      TX_INHIBIT: begin
        if (tmr_zero) begin
          state_d    = TX_REQ;
          data_drv_d = 1'b1;
          bit_cnt_d  = 4'd0;
          tmr_d      = WD_LOAD;
        end else begin
          clk_drv_d = 1'b1;
          tmr_d     = tmr_q - TMR_W'(1);
        end
      end
      TX_REQ: begin
        data_drv_d = data_drv_q;
        if (fe) begin
          data_drv_d = ~tx_frame[bit_cnt_q];
          bit_cnt_d  = bit_cnt_q + 4'd1;
          tmr_d      = WD_LOAD;
          if (bit_cnt_q == 4'd9) state_d = TX_ACK;
        end else if (tmr_zero) begin
          state_d    = IDLE;
          tx_err_d   = 1'b1;
          data_drv_d = 1'b0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      TX_ACK: begin
        if (fe) begin
          state_d = IDLE;
          if (!data_s) tx_done_d = 1'b1;
          else         tx_err_d  = 1'b1;
        end else if (tmr_zero) begin
          state_d  = IDLE;
          tx_err_d = 1'b1;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    tx_ready_d = (state_d == IDLE);
  end

  // Receive FIFO: first-word fall-through; a pop in the same cycle frees a slot for a push when full.
  logic [7:0]       fifo_mem_q [RX_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fifo_full, fifo_empty, fifo_pop, fifo_push;

  assign fifo_full  = (count_q == CNT_W'(RX_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign fifo_pop   = rx_rd & ~fifo_empty;
  assign fifo_push  = frame_ok & (~fifo_full | fifo_pop);
  assign rx_ovf_d   = frame_ok & fifo_full & ~fifo_pop;
  assign wr_ptr_d   = wr_ptr_q + PTR_W'(fifo_push);
  assign rd_ptr_d   = rd_ptr_q + PTR_W'(fifo_pop);
  assign count_d    = count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

  // NOTE: the storage array is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem_q[wr_ptr_q] <= shift_d[8:1];
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_byte_q   <= '0;
      tmr_q       <= '0;
      clk_drv_q   <= 1'b0;
      data_drv_q  <= 1'b0;
      tx_ready_q  <= 1'b0;
      tx_done_q   <= 1'b0;
      tx_err_q    <= 1'b0;
      rx_err_q    <= 1'b0;
      rx_ovf_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_byte_q   <= tx_byte_d;
      tmr_q       <= tmr_d;
      clk_drv_q   <= clk_drv_d;
      data_drv_q  <= data_drv_d;
      tx_ready_q  <= tx_ready_d;
      tx_done_q   <= tx_done_d;
      tx_err_q    <= tx_err_d;
      rx_err_q    <= rx_err_d;
      rx_ovf_q    <= rx_ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign ps2_clk_q   = clk_drv_q;
  assign ps2_data_q  = data_drv_q;
  assign tx_ready    = tx_ready_q;
  assign tx_done     = tx_done_q;
  assign tx_err      = tx_err_q;
  assign rx_err      = rx_err_q;
  assign rx_overflow = rx_ovf_q;
  assign rx_valid    = ~fifo_empty;
  assign rx_count    = count_q;
  assign rx_data     = fifo_empty ? 8'h00 : fifo_mem_q[rd_ptr_q];

endmodule
